bure_alu_arbiter: RTL and testbench
===================================

BURE_ALU_ARBITER -- requirements
Module: bure_alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and SHALL set the operand and result width.
REQ-002 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req_valid  input  2  per-requester request valid; bit k belongs to requester k.
REQ-006 o_req_ready  output  2  per-requester request accept; a request transfers when valid and ready are both high.
REQ-007 i_req_funct3  input  2x3  per-requester ALU funct3.
REQ-008 i_req_funct7  input  2x7  per-requester ALU funct7.
REQ-009 i_req_force_add  input  2  per-requester force-add, used for load/store address generation.
REQ-010 i_req_lhs, i_req_rhs  input  2xDATA_WIDTH each  per-requester operands.
REQ-011 o_rsp_valid  output  2  per-requester response valid; at most one bit is high.
REQ-012 i_rsp_ready  input  2  per-requester response accept.
REQ-013 o_rsp_data  output  DATA_WIDTH  result of the shared ALU, shared by both requesters.

Function
REQ-014 The block SHALL contain one bure_alu instance, time-shared between the two requesters, with one transaction in flight at a time.
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
- IDLE -> EXEC when any request is accepted.
- EXEC -> RESP unconditionally after one cycle.
- RESP -> IDLE when o_rsp_valid[g] and i_rsp_ready[g] are both high, where g is the granted requester.
REQ-016 In IDLE, o_req_ready SHALL be one-hot to the winning valid requester and zero if no requester is valid; in EXEC and RESP, o_req_ready SHALL be 2'b00.
REQ-017 o_req_ready SHALL depend only on i_req_valid and state; no ready-waits-for-valid loop beyond the arbitration.
REQ-018 On accept, the block SHALL capture funct3, funct7, force_add, lhs, rhs and the grant index g into registers.
REQ-019 In EXEC, the ALU SHALL be driven from the captured registers, and its output SHALL be registered into o_rsp_data on the EXEC->RESP edge.
REQ-020 o_rsp_valid[g] SHALL rise exactly two cycles after the accept edge.
REQ-021 o_rsp_data and o_rsp_valid SHALL remain stable in RESP until the handshake completes (backpressure holds indefinitely).
REQ-022 The response handshake and the next accept SHALL NOT occur in the same cycle; a new accept is possible in the first IDLE cycle after the handshake. Throughput is one operation per 3 cycles at most.
REQ-023 Default arbitration SHALL be round-robin:
- a 1-bit last-grant pointer updates on every accept;
- when both requesters are valid, the requester not last granted wins;
- a single valid requester always wins.
REQ-024 Requester inputs SHALL be ignored while the requester is not being accepted; a requester is permitted to drop valid before being accepted.
REQ-025 i_rsp_ready of the non-granted requester SHALL have no effect.
REQ-026 ALU operation selection SHALL follow bure_alu semantics: force_add takes priority; funct7=0x20 selects SUB/SRA; an unused funct3 yields 0.

Reset
REQ-027 Reset assertion SHALL immediately drive state=IDLE, o_rsp_valid=2'b00, o_rsp_data=0, last-grant pointer=1 (so requester 0 wins the first contention) and all captured registers to 0.
REQ-028 Reset asserted mid-operation (EXEC or RESP) SHALL abort the transaction with no response, and no response SHALL be issued after deassertion.
REQ-029 o_req_ready SHALL be 2'b00 while i_rst_n is low.

Configuration
REQ-030 Macro BURE_ALU_ARB_FIXED_PRIO_EN:
- when defined, arbitration SHALL be fixed priority, with requester 0 always winning contention and the last-grant pointer removed;
- when undefined, round-robin per REQ-023 SHALL apply.
All other behaviour SHALL be identical in both builds.

Verification
REQ-031 Req0 ADD, lhs=5, rhs=7, funct3=0, funct7=0, rsp_ready=1 -> ready[0] high in the accept cycle; rsp_valid=2'b01 with data=12 two cycles later for one cycle.
REQ-032 Req1 SUB, lhs=10, rhs=3, funct7=0x20 -> rsp_valid=2'b10, data=7; the same operands with force_add=1 -> data=13.
REQ-033 Both requesters valid continuously for 4 transactions, round-robin build -> grant order 0,1,0,1. Fixed-priority build -> 0,0,0,0 with req1 starved.
REQ-034 Req0 XOR, lhs=0xF0F0_F0F0, rhs=0xFFFF_0000, rsp_ready low for 5 cycles -> rsp_valid and data=0x0F0F_F0F0 held stable throughout; o_req_ready=0 throughout; accept resumes in the cycle after the handshake.
REQ-035 Reset pulsed during EXEC, then req1 valid -> no stale response appears; req1 is accepted first with a fresh result two cycles later.
REQ-036 funct3 for SRL/SRA with lhs=0x8000_0000, rhs=4 -> funct7=0 gives 0x0800_0000; funct7=0x20 gives 0xF800_0000.

Source files
------------

// File: rtl/bure_alu_arb_if.sv
// Request/response bus between two ALU clients and the shared-ALU arbiter.
// Fields carry the arbiter-side i_/o_ direction names; the master modport is the client view.
interface bure_alu_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 i_req_valid;
    logic [1:0]                 o_req_ready;
    logic [1:0][2:0]            i_req_funct3;
    logic [1:0][6:0]            i_req_funct7;
    logic [1:0]                 i_req_force_add;
    logic [1:0][DATA_WIDTH-1:0] i_req_lhs;
    logic [1:0][DATA_WIDTH-1:0] i_req_rhs;
    logic [1:0]                 o_rsp_valid;
    logic [1:0]                 i_rsp_ready;
    logic [DATA_WIDTH-1:0]      o_rsp_data;

    modport slave (
        input  i_req_valid, i_req_funct3, i_req_funct7, i_req_force_add,
        input  i_req_lhs, i_req_rhs, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data
    );

    modport master (
        output i_req_valid, i_req_funct3, i_req_funct7, i_req_force_add,
        output i_req_lhs, i_req_rhs, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data
    );
endinterface

// File: rtl/bure_alu_arbiter.sv
// Two-requester arbiter time-sharing one bure_alu, one operation in flight.
// Define BURE_ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module bure_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_funct3,
    input  logic [6:0]            i_funct7,
    input  logic                  i_force_add,
    input  logic [DATA_WIDTH-1:0] i_lhs,
    input  logic [DATA_WIDTH-1:0] i_rhs,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic           w_alt;
    logic [SHW-1:0] w_shamt;

    assign w_alt   = (i_funct7 == 7'h20);
    assign w_shamt = i_rhs[SHW-1:0];

    always_comb begin
        o_result = '0;
        if (i_force_add) begin
            o_result = i_lhs + i_rhs;
        end else begin
            case (i_funct3)
                3'd0:    o_result = w_alt ? (i_lhs - i_rhs) : (i_lhs + i_rhs);
                3'd1:    o_result = i_lhs << w_shamt;
                3'd2:    o_result = DATA_WIDTH'($signed(i_lhs) < $signed(i_rhs));
                3'd3:    o_result = DATA_WIDTH'(i_lhs < i_rhs);
                3'd4:    o_result = i_lhs ^ i_rhs;
                3'd5:    o_result = w_alt ? DATA_WIDTH'($signed(i_lhs) >>> w_shamt)
                                          : (i_lhs >> w_shamt);
                3'd6:    o_result = i_lhs | i_rhs;
                3'd7:    o_result = i_lhs & i_rhs;
                default: o_result = '0;
            endcase
        end
    end
endmodule

// state | meaning
// IDLE  | arbitrating; ready offered to the winning valid requester
// EXEC  | captured operands drive the ALU; result registered on exit
// RESP  | response held on o_rsp_valid[g] until the granted requester takes it
module bure_alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bure_alu_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_funct3;
    logic [6:0]            r_funct7;
    logic                  r_force_add;
    logic [DATA_WIDTH-1:0] r_lhs;
    logic [DATA_WIDTH-1:0] r_rhs;
    logic                  r_gnt;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_win;
    logic [1:0]            w_req_ready;
    logic                  w_accept;
    logic                  w_rsp_done;
    logic [DATA_WIDTH-1:0] w_alu_result;
`ifndef BURE_ALU_ARB_FIXED_PRIO_EN
    logic                  r_last;
`endif

    // Winner depends only on valid and state; reset gates ready off asynchronously.
    always_comb begin
        w_win = ~bus.i_req_valid[0];
`ifndef BURE_ALU_ARB_FIXED_PRIO_EN
        if (&bus.i_req_valid) w_win = ~r_last;
`endif
        w_req_ready = 2'b00;
        if (r_state == IDLE && i_rst_n && |bus.i_req_valid) w_req_ready[w_win] = 1'b1;
    end

    assign w_accept   = |w_req_ready;
    assign w_rsp_done = r_rsp_valid[r_gnt] & bus.i_rsp_ready[r_gnt];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_rsp_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    bure_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_funct3    (r_funct3),
        .i_funct7    (r_funct7),
        .i_force_add (r_force_add),
        .i_lhs       (r_lhs),
        .i_rhs       (r_rhs),
        .o_result    (w_alu_result)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_force_add <= 1'b0;
            r_lhs       <= '0;
            r_rhs       <= '0;
            r_gnt       <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_funct3    <= bus.i_req_funct3[w_win];
                r_funct7    <= bus.i_req_funct7[w_win];
                r_force_add <= bus.i_req_force_add[w_win];
                r_lhs       <= bus.i_req_lhs[w_win];
                r_rhs       <= bus.i_req_rhs[w_win];
                r_gnt       <= w_win;
            end
            if (r_state == EXEC) begin
                r_rsp_data  <= w_alu_result;
                r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
            end else if (r_state == RESP && w_rsp_done) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

`ifndef BURE_ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_last <= 1'b1;
        else if (w_accept) r_last <= w_win;
    end
`endif

    assign bus.o_req_ready = w_req_ready;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_bure_alu_arbiter.sv
// Directed bench for bure_alu_arbiter; expectations follow BURE_ALU_ARB_FIXED_PRIO_EN if defined.
module tb_bure_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bure_alu_arb_if #(.DATA_WIDTH(32)) bus ();

    bure_alu_arbiter #(.DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [2:0] f3, input logic [6:0] f7,
                           input logic fa, input logic [31:0] a, input logic [31:0] b);
        bus.i_req_funct3[k]    = f3;
        bus.i_req_funct7[k]    = f7;
        bus.i_req_force_add[k] = fa;
        bus.i_req_lhs[k]       = a;
        bus.i_req_rhs[k]       = b;
    endtask

    // Single-requester operation from IDLE with the response taken immediately.
    task automatic run_op(input int k, input logic [2:0] f3, input logic [6:0] f7, input logic fa,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input string tag);
        logic [1:0] oh;
        oh = (k == 1) ? 2'b10 : 2'b01;
        set_req(k, f3, f7, fa, a, b);
        bus.i_req_valid = oh;
        #1 chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'(oh));
        tick();
        bus.i_req_valid = 2'b00;
        #1 chk({tag, "_exec_valid"}, 32'(bus.o_rsp_valid), 32'h0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'(oh));
        chk({tag, "_data"}, bus.o_rsp_data, exp);
        tick();
        chk({tag, "_done"}, 32'(bus.o_rsp_valid), 32'h0);
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        set_req(0, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7);
        set_req(1, 3'd0, 7'h00, 1'b0, 32'd9, 32'd9);
        #3;
        chk("rst_ready", 32'(bus.o_req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("rst_data", bus.o_rsp_data, 32'h0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        bus.i_req_valid = 2'b00;
        #1 chk("idle_no_valid_ready", 32'(bus.o_req_ready), 32'h0);

        // First contention after reset goes to requester 0 in both builds.
        bus.i_req_valid = 2'b11;
        #1 chk("add_first_contention", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 2'b00;
        #1 chk("add_exec_ready", 32'(bus.o_req_ready), 32'h0);
        tick();
        chk("add_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
        chk("add_data", bus.o_rsp_data, 32'd12);
        tick();
        chk("add_one_cycle", 32'(bus.o_rsp_valid), 32'h0);

        run_op(1, 3'd0, 7'h20, 1'b0, 32'd10, 32'd3, 32'd7, "sub");
        run_op(1, 3'd0, 7'h20, 1'b1, 32'd10, 32'd3, 32'd13, "force_add");

        set_req(0, 3'd0, 7'h00, 1'b0, 32'd100, 32'd1);
        set_req(1, 3'd0, 7'h00, 1'b0, 32'd200, 32'd2);
        bus.i_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef BURE_ALU_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_d = (exp_g == 2'b01) ? 32'd101 : 32'd202;
            #1 chk($sformatf("rr%0d_grant", i), 32'(bus.o_req_ready), 32'(exp_g));
            tick();
            tick();
            chk($sformatf("rr%0d_rsp_valid", i), 32'(bus.o_rsp_valid), 32'(exp_g));
            chk($sformatf("rr%0d_data", i), bus.o_rsp_data, exp_d);
            tick();
        end
        bus.i_req_valid = 2'b00;

        // Backpressure; the non-granted requester's ready must not release the response.
        set_req(0, 3'd4, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        set_req(1, 3'd0, 7'h00, 1'b0, 32'd1, 32'd1);
        bus.i_req_valid = 2'b01;
        bus.i_rsp_ready = 2'b10;
        #1 chk("bp_accept", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 2'b10;
        #1 chk("bp_exec_ready", 32'(bus.o_req_ready), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_valid", i), 32'(bus.o_rsp_valid), 32'h1);
            chk($sformatf("bp%0d_data", i), bus.o_rsp_data, 32'h0F0F_F0F0);
            chk($sformatf("bp%0d_ready", i), 32'(bus.o_req_ready), 32'h0);
            tick();
        end
        bus.i_rsp_ready = 2'b01;
        #1 chk("bp_handshake_valid", 32'(bus.o_rsp_valid), 32'h1);
        chk("bp_handshake_ready", 32'(bus.o_req_ready), 32'h0);
        tick();
        bus.i_rsp_ready = 2'b11;
        #1 chk("bp_after_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("bp_resume_accept", 32'(bus.o_req_ready), 32'h2);
        tick();
        bus.i_req_valid = 2'b00;
        tick();
        chk("bp_req1_valid", 32'(bus.o_rsp_valid), 32'h2);
        chk("bp_req1_data", bus.o_rsp_data, 32'd2);
        tick();

        // Reset during EXEC aborts the transaction.
        set_req(0, 3'd0, 7'h00, 1'b0, 32'd1, 32'd2);
        bus.i_req_valid = 2'b01;
        #1 chk("abort_accept", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 2'b00;
        rst_n = 1'b0;
        #1 chk("abort_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("abort_data", bus.o_rsp_data, 32'h0);
        bus.i_req_valid = 2'b10;
        #1 chk("abort_ready_in_rst", 32'(bus.o_req_ready), 32'h0);
        bus.i_req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_no_stale", 32'(bus.o_rsp_valid), 32'h0);
        run_op(1, 3'd0, 7'h00, 1'b0, 32'd20, 32'd22, 32'd42, "post_rst");

        run_op(0, 3'd5, 7'h00, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        run_op(1, 3'd5, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
        run_op(0, 3'd7, 7'h00, 1'b0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, "and");
        run_op(1, 3'd2, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        run_op(0, 3'd3, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        run_op(1, 3'd1, 7'h00, 1'b0, 32'd1, 32'd31, 32'h8000_0000, "sll");
        run_op(0, 3'd6, 7'h00, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "or");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
